// File: rtl/huffman_mcu_scheduler.sv
// Huffman MCU scheduler: shares one Huffman coder between the Y/Cb/Cr
// run-length streams. It walks the MCU component order one whole block per
// slot and tags every forwarded beat with its component and table set.

package huffman_mcu_pkg;
    // Run-length symbol handed from the zigzag/RLE stage to the Huffman coder.
    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic        done;
        logic [3:0]  run;
        logic [3:0]  size;
        logic [11:0] amp;
    } tempCode_t;
endpackage

module huffman_mcu_scheduler
    import huffman_mcu_pkg::*;
#(
    parameter int MCU_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 cfg_420,
    input  logic [MCU_CNT_W-1:0] cfg_mcu_count,
    input  tempCode_t            y_in,
    input  tempCode_t            cb_in,
    input  tempCode_t            cr_in,
    output logic                 y_rdy,
    output logic                 cb_rdy,
    output logic                 cr_rdy,
    output tempCode_t            out,
    input  logic                 out_rdy,
    output logic                 out_chroma,
    output logic [1:0]           out_comp,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 sop_err
);

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        NEXT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    logic                 is_420;
    logic [MCU_CNT_W-1:0] mcu_total;
    logic [MCU_CNT_W-1:0] mcu;
    logic [2:0]           slot;
    logic                 in_block;   // SOP of the current slot already forwarded

    logic [1:0]           sel_comp;
    tempCode_t            sel_in;
    tempCode_t            beat_next;
    logic                 last_slot;
    logic                 last_mcu;
    logic                 can_take;
    logic                 take;
    logic                 bad_sop;
    logic                 fwd;

    // Map the slot position inside the MCU to the component it carries.
    always_comb begin
        sel_comp = COMP_Y;
        if (is_420) begin
            if (slot == 3'd4)      sel_comp = COMP_CB;
            else if (slot == 3'd5) sel_comp = COMP_CR;
        end else begin
            if (slot == 3'd1)      sel_comp = COMP_CB;
            else if (slot == 3'd2) sel_comp = COMP_CR;
        end
    end

    // Select the active stream and form the beat that would be registered.
    always_comb begin
        case (sel_comp)
            COMP_CB: sel_in = cb_in;
            COMP_CR: sel_in = cr_in;
            default: sel_in = y_in;
        endcase
        last_slot = is_420 ? (slot == 3'd5) : (slot == 3'd2);
        // Compare before incrementing so mcu never needs to wrap.
        last_mcu  = ({1'b0, mcu} + 1'b1) == {1'b0, mcu_total};
        beat_next       = sel_in;
        beat_next.valid = 1'b1;
        beat_next.done  = sel_in.eop && last_slot && last_mcu;
    end

    // Handshake: only the selected stream sees ready, and only when the
    // output register is empty or draining this cycle.
    always_comb begin
        can_take = (state == PASS) && (!out.valid || out_rdy);
        y_rdy    = can_take && (sel_comp == COMP_Y);
        cb_rdy   = can_take && (sel_comp == COMP_CB);
        cr_rdy   = can_take && (sel_comp == COMP_CR);
        take     = can_take && sel_in.valid;
        // A slot must open with SOP; anything else is swallowed.
        bad_sop  = take && !in_block && !sel_in.sop;
        fwd      = take && !bad_sop;
    end

    // Scheduler FSM, counters and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_420     <= 1'b0;
            mcu_total  <= '0;
            mcu        <= '0;
            slot       <= '0;
            in_block   <= 1'b0;
            out        <= '0;
            out_chroma <= 1'b0;
            out_comp   <= COMP_Y;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sop_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (fwd) begin
                out        <= beat_next;
                out_comp   <= sel_comp;
                out_chroma <= (sel_comp != COMP_Y);
            end else if (out_rdy) begin
                out.valid  <= 1'b0;
            end

            if (bad_sop) begin
                sop_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        is_420    <= cfg_420;
                        mcu_total <= cfg_mcu_count;
                        slot      <= '0;
                        mcu       <= '0;
                        in_block  <= 1'b0;
                        busy      <= 1'b1;
                        sop_err   <= 1'b0;
                        state     <= (cfg_mcu_count == '0) ? DONE : PASS;
                    end
                end
                PASS: begin
                    if (fwd) begin
                        if (sel_in.eop) begin
                            in_block <= 1'b0;
                            state    <= NEXT;
                        end else begin
                            in_block <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (last_slot) begin
                        slot  <= '0;
                        mcu   <= mcu + 1'b1;
                        state <= last_mcu ? DONE : PASS;
                    end else begin
                        slot  <= slot + 3'd1;
                        state <= PASS;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_mcu_scheduler.sv
// Bench for huffman_mcu_scheduler: random blocks per stream, expected output
// built from the MCU ordering rules, per-beat comparison of the coder side.

module tb_huffman_mcu_scheduler;
    import huffman_mcu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cfg_420;
    logic [15:0] cfg_mcu_count;
    tempCode_t   y_in, cb_in, cr_in, out;
    logic        y_rdy, cb_rdy, cr_rdy;
    logic        out_rdy, out_chroma, busy, frame_done, sop_err;
    logic [1:0]  out_comp;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        tempCode_t  b;
        logic [1:0] comp;
        logic       chroma;
    } rec_t;

    tempCode_t qy[$];
    tempCode_t qb[$];
    tempCode_t qr[$];
    rec_t      expq[$];
    rec_t      gotq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    huffman_mcu_scheduler #(.MCU_CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_420       (cfg_420),
        .cfg_mcu_count (cfg_mcu_count),
        .y_in          (y_in),
        .cb_in         (cb_in),
        .cr_in         (cr_in),
        .y_rdy         (y_rdy),
        .cb_rdy        (cb_rdy),
        .cr_rdy        (cr_rdy),
        .out           (out),
        .out_rdy       (out_rdy),
        .out_chroma    (out_chroma),
        .out_comp      (out_comp),
        .busy          (busy),
        .frame_done    (frame_done),
        .sop_err       (sop_err)
    );

    function automatic tempCode_t rand_beat(bit v, bit sop, bit eop);
        logic [31:0] r;
        tempCode_t   b;
        r = $urandom;
        b = r[$bits(tempCode_t)-1:0];
        b.valid = v;
        b.sop   = sop;
        b.eop   = eop;
        return b;
    endfunction

    task automatic push_stream(input int comp, input tempCode_t b);
        if (comp == 0)      qy.push_back(b);
        else if (comp == 1) qb.push_back(b);
        else                qr.push_back(b);
    endtask

    // Reference model: per MCU, the component order is Y Cb Cr (4:4:4) or
    // Y Y Y Y Cb Cr (4:2:0). Each slot yields one block from its stream.
    task automatic build_frame(input bit is420, input int nmcu, input int junk_slot,
                               input int fixed_len);
        int   g;
        int   nslots;
        int   comp;
        int   len;
        rec_t e;
        tempCode_t b;
        qy.delete(); qb.delete(); qr.delete(); expq.delete();
        g = 0;
        nslots = is420 ? 6 : 3;
        for (int m = 0; m < nmcu; m++) begin
            for (int s = 0; s < nslots; s++) begin
                if (is420) comp = (s < 4) ? 0 : s - 3;
                else       comp = s;
                if (g == junk_slot)
                    push_stream(comp, rand_beat(1'b1, 1'b0, 1'($urandom_range(0, 1))));
                len = (fixed_len > 0) ? fixed_len : $urandom_range(1, 4);
                for (int i = 0; i < len; i++) begin
                    b = rand_beat(1'b1, i == 0, i == len - 1);
                    push_stream(comp, b);
                    e.b      = b;
                    e.b.done = (i == len - 1) && (m == nmcu - 1) && (s == nslots - 1);
                    e.comp   = 2'(comp);
                    e.chroma = (comp != 0);
                    expq.push_back(e);
                end
                g++;
            end
        end
    endtask

    task automatic idle_inputs();
        y_in  = rand_beat(1'b0, 1'b0, 1'b0);
        cb_in = rand_beat(1'b0, 1'b0, 1'b0);
        cr_in = rand_beat(1'b0, 1'b0, 1'b0);
        start = 1'b0;
    endtask

    // Drive one frame; rdy_mode 0 = always ready, 1 = toggling, 2 = random.
    task automatic run_frame(input bit is420, input int nmcu, input int rdy_mode,
                             input bit gaps, input int restart_at, input int abort_at,
                             output int last_fire, output int fd_cycle, output int rdy_seen);
        int        cyc;
        int        viol;
        int        nrdy;
        bit        fd_seen;
        bit        prev_hold;
        bit        acc_y, acc_b, acc_r;
        rec_t      prev_rec;
        rec_t      cur;
        logic [31:0] r;
        cyc = 0; viol = 0; fd_seen = 0; prev_hold = 0;
        last_fire = -1; fd_cycle = -1; rdy_seen = 0;
        gotq.delete();
        while (cyc < 4000) begin
            @(negedge clk);
            start = (cyc == 0) || (cyc == restart_at);
            if (cyc == 0) begin
                cfg_420       = is420;
                cfg_mcu_count = 16'(nmcu);
            end else begin
                r = $urandom;
                cfg_420       = r[16];
                cfg_mcu_count = r[15:0];
            end
            y_in  = (qy.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) ? qy[0] : rand_beat(1'b0, 1'b0, 1'b0);
            cb_in = (qb.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) ? qb[0] : rand_beat(1'b0, 1'b0, 1'b0);
            cr_in = (qr.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) ? qr[0] : rand_beat(1'b0, 1'b0, 1'b0);
            if (fd_seen || rdy_mode == 0) out_rdy = 1'b1;
            else if (rdy_mode == 1)       out_rdy = (cyc % 2 == 0);
            else                          out_rdy = 1'($urandom_range(0, 1));
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({out.valid, busy, frame_done, sop_err, y_rdy, cb_rdy, cr_rdy, out_chroma, out_comp} !== 10'd0) begin
                    errors++;
                    $display("FAIL async_reset: got valid=%0b busy=%0b fd=%0b err=%0b rdy=%0b%0b%0b chroma=%0b comp=%0d, want all 0",
                             out.valid, busy, frame_done, sop_err, y_rdy, cb_rdy, cr_rdy, out_chroma, out_comp);
                end
                idle_inputs();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            #1;
            cur.b = out; cur.comp = out_comp; cur.chroma = out_chroma;
            if (prev_hold) begin
                checks++;
                if (cur !== prev_rec) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d: got %h, want %h", cyc, cur, prev_rec);
                end
            end
            prev_hold = out.valid && !out_rdy;
            prev_rec  = cur;
            if (out.valid && out_rdy) begin
                gotq.push_back(cur);
                last_fire = cyc;
            end
            nrdy = int'(y_rdy) + int'(cb_rdy) + int'(cr_rdy);
            rdy_seen += nrdy;
            if (nrdy > 1) viol++;
            if (nrdy > 0 && out.valid && !out_rdy) viol++;
            acc_y = y_in.valid && y_rdy;
            acc_b = cb_in.valid && cb_rdy;
            acc_r = cr_in.valid && cr_rdy;
            if (frame_done) begin
                if (fd_seen) viol++;
                fd_seen  = 1;
                fd_cycle = cyc;
            end
            if (fd_seen && !out.valid) break;
            @(posedge clk);
            if (acc_y) void'(qy.pop_front());
            if (acc_b) void'(qb.pop_front());
            if (acc_r) void'(qr.pop_front());
            cyc++;
        end
        idle_inputs();
        checks++;
        if (!fd_seen) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_done in %0d cycles, want one", cyc);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL handshake_rules: got %0d violations, want 0", viol);
        end
        checks++;
        if (gotq.size() != expq.size()) begin
            errors++;
            $display("FAIL beat_count: got %0d, want %0d", gotq.size(), expq.size());
        end
        for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
            checks++;
            if (gotq[i] !== expq[i]) begin
                errors++;
                $display("FAIL beat[%0d]: got beat=%h comp=%0d chroma=%0b, want beat=%h comp=%0d chroma=%0b",
                         i, gotq[i].b, gotq[i].comp, gotq[i].chroma, expq[i].b, expq[i].comp, expq[i].chroma);
            end
        end
    endtask

    task automatic check_idle(input string name, input logic want_err);
        checks++;
        if (busy !== 1'b0 || sop_err !== want_err) begin
            errors++;
            $display("FAIL %s: got busy=%0b sop_err=%0b, want busy=0 sop_err=%0b", name, busy, sop_err, want_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_rdy = 1'b0; cfg_420 = 1'b0; cfg_mcu_count = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out, busy, frame_done, sop_err, y_rdy, cb_rdy, cr_rdy, out_chroma, out_comp} !== '0) begin
            errors++;
            $display("FAIL reset_state: got out=%h busy=%0b fd=%0b err=%0b, want all 0", out, busy, frame_done, sop_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_444_basic();
        int lf, fd, rs;
        build_frame(1'b0, 1, -1, 2);
        run_frame(1'b0, 1, 0, 1'b0, -1, -1, lf, fd, rs);
        checks++;
        if (fd - lf != 2) begin
            errors++;
            $display("FAIL frame_done_latency: got %0d cycles after last beat, want 2", fd - lf);
        end
        check_idle("basic_444_idle", 1'b0);
        $display("test_444_basic: last_fire=%0d frame_done=%0d", lf, fd);
    endtask

    task automatic test_420_two_mcu();
        int lf, fd, rs;
        build_frame(1'b1, 2, -1, 0);
        run_frame(1'b1, 2, 0, 1'b0, -1, -1, lf, fd, rs);
        check_idle("two_mcu_420_idle", 1'b0);
        $display("test_420_two_mcu: beats=%0d", gotq.size());
    endtask

    task automatic test_backpressure();
        int lf, fd, rs;
        build_frame(1'b1, 2, -1, 0);
        run_frame(1'b1, 2, 1, 1'b1, -1, -1, lf, fd, rs);
        check_idle("toggle_rdy_idle", 1'b0);
        build_frame(1'b0, 3, -1, 0);
        run_frame(1'b0, 3, 2, 1'b1, -1, -1, lf, fd, rs);
        check_idle("random_rdy_idle", 1'b0);
        $display("test_backpressure: beats=%0d", gotq.size());
    endtask

    task automatic test_sop_error();
        int lf, fd, rs;
        build_frame(1'b0, 1, 0, 0);
        run_frame(1'b0, 1, 0, 1'b1, -1, -1, lf, fd, rs);
        check_idle("sop_err_luma", 1'b1);
        build_frame(1'b1, 1, 4, 0);
        run_frame(1'b1, 1, 2, 1'b1, -1, -1, lf, fd, rs);
        check_idle("sop_err_chroma", 1'b1);
        build_frame(1'b0, 1, -1, 0);
        run_frame(1'b0, 1, 0, 1'b0, -1, -1, lf, fd, rs);
        check_idle("sop_err_cleared", 1'b0);
        $display("test_sop_error done");
    endtask

    task automatic test_zero_count();
        int nrdy;
        nrdy = 0;
        @(negedge clk);
        start = 1'b1; cfg_420 = 1'b1; cfg_mcu_count = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        nrdy += int'(y_rdy) + int'(cb_rdy) + int'(cr_rdy);
        checks++;
        if (busy !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_count_c1: got busy=%0b fd=%0b, want busy=1 fd=0", busy, frame_done);
        end
        @(negedge clk);
        #1;
        nrdy += int'(y_rdy) + int'(cb_rdy) + int'(cr_rdy);
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_count_c2: got busy=%0b fd=%0b, want busy=0 fd=1", busy, frame_done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0 || nrdy != 0) begin
            errors++;
            $display("FAIL zero_count_c3: got fd=%0b rdy_count=%0d, want fd=0 rdy_count=0", frame_done, nrdy);
        end
        $display("test_zero_count done");
    endtask

    task automatic test_start_while_busy();
        int lf, fd, rs;
        build_frame(1'b0, 2, -1, 0);
        run_frame(1'b0, 2, 0, 1'b1, 5, -1, lf, fd, rs);
        check_idle("restart_ignored_idle", 1'b0);
        $display("test_start_while_busy: beats=%0d", gotq.size());
    endtask

    task automatic test_async_reset();
        int lf, fd, rs;
        build_frame(1'b0, 1, -1, 4);
        run_frame(1'b0, 1, 0, 1'b0, -1, 3, lf, fd, rs);
        build_frame(1'b0, 1, -1, 2);
        run_frame(1'b0, 1, 0, 1'b0, -1, -1, lf, fd, rs);
        check_idle("after_reset_idle", 1'b0);
        $display("test_async_reset: post-reset frame beats=%0d", gotq.size());
    endtask

    initial begin
        test_reset();
        test_444_basic();
        test_420_two_mcu();
        test_backpressure();
        test_sop_error();
        test_zero_count();
        test_start_while_busy();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
